// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and helpers for the pipelined add/subtract unit
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // One CHUNK-wide slice is resolved per pipeline stage.
    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/fa_chunk.sv
// rtl/fa_chunk.sv - combinational W-bit full adder slice
module fa_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder_sub.sv
// rtl/pipelined_adder_sub.sv - pipelined add/subtract, one CHUNK slice per stage, valid/ready handshake
module pipelined_adder_sub
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);
    localparam int MSB    = WIDTH - 1;

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("pipelined_adder_sub: WIDTH must be a multiple of CHUNK");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             carry_in;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    assign b_eff    = (sub == MODE_SUB) ? ~b : b;
    assign carry_in = (sub == MODE_SUB);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             v_q;

        logic [WIDTH-1:0] a_d;
        logic [WIDTH-1:0] b_d;
        logic [WIDTH-1:0] s_prev;
        logic [WIDTH-1:0] s_d;
        logic             c_d;
        logic             v_d;
        logic [CHUNK-1:0] slice_s;
        logic             slice_c;

        if (k == 0) begin : g_first
            assign a_d    = a;
            assign b_d    = b_eff;
            assign s_prev = '0;
            assign c_d    = carry_in;
            assign v_d    = in_valid;
        end else begin : g_next
            assign a_d    = g_stage[k-1].a_q;
            assign b_d    = g_stage[k-1].b_q;
            assign s_prev = g_stage[k-1].s_q;
            assign c_d    = g_stage[k-1].c_q;
            assign v_d    = g_stage[k-1].v_q;
        end

        fa_chunk #(
            .W(CHUNK)
        ) u_fa (
            .a    (a_d[k*CHUNK +: CHUNK]),
            .b    (b_d[k*CHUNK +: CHUNK]),
            .cin  (c_d),
            .s    (slice_s),
            .cout (slice_c)
        );

        // Earlier result slices ride along; this stage fills in its own slice.
        always_comb begin
            s_d                    = s_prev;
            s_d[k*CHUNK +: CHUNK]  = slice_s;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                a_q <= a_d;
                b_q <= b_d;
                s_q <= s_d;
                c_q <= slice_c;
                v_q <= v_d;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    // Signed overflow: operands share a sign that the result does not.
    assign ovf       = (g_stage[STAGES-1].a_q[MSB] == g_stage[STAGES-1].b_q[MSB]) &
                       (g_stage[STAGES-1].s_q[MSB] != g_stage[STAGES-1].a_q[MSB]);

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// tb/tb_pipelined_adder_sub.sv - self-checking bench for pipelined_adder_sub
module tb_pipelined_adder_sub;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    pipelined_adder_sub #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc_cyc;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    exp_t             sb[$];
    int               out_cycles[$];
    int               cyc = 0;
    bit               lat_check = 1'b0;
    bit               took = 1'b0;
    int               tests = 0;
    int               fails = 0;
    logic [WIDTH-1:0] es;
    logic             ec;
    logic             eo;
    exp_t             popped;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                   input logic s_i);
        exp_t             r;
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   t;
        be        = s_i ? ~b_i : b_i;
        t         = {1'b0, a_i} + {1'b0, be} + {{WIDTH{1'b0}}, s_i};
        r.sum     = t[WIDTH-1:0];
        r.cout    = t[WIDTH];
        r.ovf     = (a_i[WIDTH-1] == be[WIDTH-1]) && (t[WIDTH-1] != a_i[WIDTH-1]);
        r.acc_cyc = 0;
        return r;
    endfunction

    // Input side of the scoreboard: record the expectation when the transfer happens.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb.push_back('{es, ec, eo, cyc});
            took = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            out_cycles.push_back(cyc);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got sum %0h, expected no result", sum);
            end else begin
                popped = sb.pop_front();
                check("sum", {16'h0, sum}, {16'h0, popped.sum});
                check("cout", {31'h0, cout}, {31'h0, popped.cout});
                check("ovf", {31'h0, ovf}, {31'h0, popped.ovf});
                if (lat_check) check("latency", cyc - popped.acc_cyc, STAGES);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                         input logic s_i, input logic [WIDTH-1:0] es_i, input logic ec_i,
                         input logic eo_i);
        in_valid = v;
        a        = a_i;
        b        = b_i;
        sub      = s_i;
        es       = es_i;
        ec       = ec_i;
        eo       = eo_i;
        took     = 1'b0;
    endtask

    task automatic drive_model(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                               input logic s_i);
        exp_t m;
        m = model(a_i, b_i, s_i);
        drive(1'b1, a_i, b_i, s_i, m.sum, m.cout, m.ovf);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
        check("drain_remaining", sb.size(), 0);
    endtask

    vec_t vt[11];

    initial begin
        vt[0]  = '{16'd4,     16'd3,    1'b0, 16'd7,     1'b0, 1'b0};
        vt[1]  = '{16'd36,    16'd56,   1'b0, 16'd92,    1'b0, 1'b0};
        vt[2]  = '{16'd125,   16'd500,  1'b0, 16'd625,   1'b0, 1'b0};
        vt[3]  = '{16'd9000,  16'd500,  1'b0, 16'd9500,  1'b0, 1'b0};
        vt[4]  = '{16'hFFFF,  16'hFFFF, 1'b0, 16'hFFFE,  1'b1, 1'b0};
        vt[5]  = '{16'h7FFF,  16'h0001, 1'b0, 16'h8000,  1'b0, 1'b1};
        vt[6]  = '{16'd5000,  16'd500,  1'b1, 16'd4500,  1'b1, 1'b0};
        vt[7]  = '{16'h0000,  16'h0001, 1'b1, 16'hFFFF,  1'b0, 1'b0};
        vt[8]  = '{16'h8000,  16'h0001, 1'b1, 16'h7FFF,  1'b1, 1'b1};
        vt[9]  = '{16'h1234,  16'h1234, 1'b1, 16'h0000,  1'b1, 1'b0};
        vt[10] = '{16'h8000,  16'h8000, 1'b0, 16'h0000,  1'b1, 1'b1};

        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        check("reset_out_valid", {31'h0, out_valid}, 0);
        check("reset_sum", {16'h0, sum}, 0);
        check("reset_cout", {31'h0, cout}, 0);
        check("reset_ovf", {31'h0, ovf}, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", {31'h0, in_ready}, 1);

        // Directed table, back-to-back at full throughput.
        lat_check = 1'b1;
        out_cycles.delete();
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vt[i].a, vt[i].b, vt[i].sub, vt[i].sum, vt[i].cout, vt[i].ovf);
            tick();
        end
        idle();
        wait_drain();
        check("table_count", out_cycles.size(), 11);
        for (int i = 1; i < out_cycles.size(); i++)
            check("table_consecutive", out_cycles[i] - out_cycles[i-1], 1);

        // Six mixed add/sub operations streamed back to back.
        out_cycles.delete();
        for (int i = 0; i < 6; i++) begin
            drive_model(16'($urandom), 16'($urandom), 1'(i % 2));
            tick();
        end
        idle();
        wait_drain();
        check("stream_count", out_cycles.size(), 6);
        for (int i = 1; i < out_cycles.size(); i++)
            check("stream_consecutive", out_cycles[i] - out_cycles[i-1], 1);

        // Backpressure with the pipe full.
        lat_check = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_model(16'(1000 * (i + 1)), 16'(7 * i + 3), 1'(i % 2));
            tick();
        end
        drive_model(16'hABCD, 16'h1111, 1'b1);
        begin
            logic [WIDTH-1:0] snap;
            @(negedge clk);
            snap = sum;
            check("bp_out_valid", {31'h0, out_valid}, 1);
            check("bp_in_ready", {31'h0, in_ready}, 0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("bp_in_ready_hold", {31'h0, in_ready}, 0);
                check("bp_out_valid_hold", {31'h0, out_valid}, 1);
                check("bp_sum_stable", {16'h0, sum}, {16'h0, snap});
            end
        end
        tick();
        out_ready = 1'b1;
        tick();
        idle();
        wait_drain();

        // One-cycle bubble gives exactly one output gap.
        lat_check = 1'b1;
        out_cycles.delete();
        drive_model(16'd10, 16'd20, 1'b0); tick();
        drive_model(16'd30, 16'd5,  1'b1); tick();
        idle();                            tick();
        drive_model(16'd77, 16'd99, 1'b1); tick();
        drive_model(16'hF00F, 16'h0FF1, 1'b0); tick();
        idle();
        wait_drain();
        check("bubble_count", out_cycles.size(), 4);
        if (out_cycles.size() == 4) begin
            check("bubble_gap0", out_cycles[1] - out_cycles[0], 1);
            check("bubble_gap1", out_cycles[2] - out_cycles[1], 2);
            check("bubble_gap2", out_cycles[3] - out_cycles[2], 1);
        end

        // Random traffic with random stalls and bubbles.
        lat_check = 1'b0;
        begin
            int sent;
            sent = 0;
            idle();
            for (int c = 0; c < 600 && sent < 30; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (!in_valid || took) begin
                    if (took) sent++;
                    if ($urandom_range(0, 3) == 0) idle();
                    else drive_model(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
                end
                tick();
            end
            check("random_sent", {31'h0, sent >= 30}, 1);
        end
        idle();
        out_ready = 1'b1;
        wait_drain();

        // Asynchronous reset with a full pipe; nothing stale may emerge.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_model(16'(300 + i), 16'(40 + i), 1'b0);
            tick();
        end
        idle();
        #1;
        check("pre_reset_out_valid", {31'h0, out_valid}, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", {31'h0, out_valid}, 0);
        check("async_reset_sum", {16'h0, sum}, 0);
        check("async_reset_cout", {31'h0, cout}, 0);
        sb.delete();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        out_cycles.delete();
        repeat (10) tick();
        check("post_reset_no_output", out_cycles.size(), 0);
        check("post_reset_in_ready", {31'h0, in_ready}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
